// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - 640x480@60 VGA timing constants and shared coordinate type
package vga_pkg;

    localparam int H_VISIBLE = 640;
    localparam int H_FRONT   = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BACK    = 48;
    localparam int V_VISIBLE = 480;
    localparam int V_FRONT   = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BACK    = 33;

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    // Raster coordinate as seen by every renderer
    typedef logic [9:0] coord_t;

endpackage

// File: rtl/wrap_counter.sv
// rtl/wrap_counter.sv - modulo-N counter with enable, wrap flag and next-state output
module wrap_counter
    import vga_pkg::coord_t;
#(
    parameter int MODULUS = 800
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    output logic [9:0] count,
    output logic [9:0] count_next,
    output logic       wrap
);

    localparam coord_t LAST = coord_t'(MODULUS - 1);

    coord_t count_q;
    coord_t count_d;

    // Next count; wrap is asserted in the enabled cycle that returns the count to zero
    always_comb begin
        wrap    = en && (count_q == LAST);
        count_d = count_q;
        if (en) begin
            count_d = wrap ? '0 : count_q + 10'd1;
        end
    end

    // Counter state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // The next-state value lets the parent register decodes aligned with the count
    assign count      = count_q;
    assign count_next = count_d;

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster timing generator with sync, blank and frame strobes
module vga_timing_gen
    import vga_pkg::coord_t;
#(
    parameter int H_VISIBLE = vga_pkg::H_VISIBLE,
    parameter int H_FRONT   = vga_pkg::H_FRONT,
    parameter int H_SYNC    = vga_pkg::H_SYNC,
    parameter int H_BACK    = vga_pkg::H_BACK,
    parameter int V_VISIBLE = vga_pkg::V_VISIBLE,
    parameter int V_FRONT   = vga_pkg::V_FRONT,
    parameter int V_SYNC    = vga_pkg::V_SYNC,
    parameter int V_BACK    = vga_pkg::V_BACK
) (
    input  logic        vga_clk,
    input  logic        reset_n,
    output logic [9:0]  DrawX,
    output logic [9:0]  DrawY,
    output logic        blank,
    output logic        hs,
    output logic        vs,
    output logic        frame_start,
    output logic        vblank_start,
    output logic [15:0] frame_count
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    // Decode bounds are one bit wider than a coordinate so a window ending at 1024 still compares correctly
    localparam logic [10:0] H_VIS_E    = 11'(H_VISIBLE);
    localparam logic [10:0] HS_START_E = 11'(H_VISIBLE + H_FRONT);
    localparam logic [10:0] HS_END_E   = 11'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [10:0] V_VIS_E    = 11'(V_VISIBLE);
    localparam logic [10:0] VS_START_E = 11'(V_VISIBLE + V_FRONT);
    localparam logic [10:0] VS_END_E   = 11'(V_VISIBLE + V_FRONT + V_SYNC);

    generate
        if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_total_check
            $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
        end
    endgenerate

    coord_t h_count;
    coord_t h_next;
    logic   h_wrap;
    coord_t v_count;
    coord_t v_next;
    logic   v_wrap;

    wrap_counter #(.MODULUS(H_TOTAL)) u_h_counter (
        .clk        (vga_clk),
        .rst_n      (reset_n),
        .en         (1'b1),
        .count      (h_count),
        .count_next (h_next),
        .wrap       (h_wrap)
    );

    wrap_counter #(.MODULUS(V_TOTAL)) u_v_counter (
        .clk        (vga_clk),
        .rst_n      (reset_n),
        .en         (h_wrap),
        .count      (v_count),
        .count_next (v_next),
        .wrap       (v_wrap)
    );

    logic        blank_d,        blank_q;
    logic        hs_d,           hs_q;
    logic        vs_d,           vs_q;
    logic        frame_start_d,  frame_start_q;
    logic        vblank_start_d, vblank_start_q;
    logic [15:0] frame_count_d,  frame_count_q;

    logic [10:0] h_next_e;
    logic [10:0] v_next_e;

    // Decode on the next counter values so every registered output describes the pixel DrawX/DrawY will show
    always_comb begin
        h_next_e       = {1'b0, h_next};
        v_next_e       = {1'b0, v_next};
        blank_d        = (h_next_e < H_VIS_E) && (v_next_e < V_VIS_E);
        hs_d           = !((h_next_e >= HS_START_E) && (h_next_e < HS_END_E));
        vs_d           = !((v_next_e >= VS_START_E) && (v_next_e < VS_END_E));
        frame_start_d  = h_wrap && v_wrap;
        vblank_start_d = h_wrap && (v_next_e == V_VIS_E);
        frame_count_d  = frame_start_d ? frame_count_q + 16'd1 : frame_count_q;
    end

    // Output registers; reset pixel (0,0) is visible, syncs idle high
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            blank_q        <= 1'b1;
            hs_q           <= 1'b1;
            vs_q           <= 1'b1;
            frame_start_q  <= 1'b0;
            vblank_start_q <= 1'b0;
            frame_count_q  <= '0;
        end else begin
            blank_q        <= blank_d;
            hs_q           <= hs_d;
            vs_q           <= vs_d;
            frame_start_q  <= frame_start_d;
            vblank_start_q <= vblank_start_d;
            frame_count_q  <= frame_count_d;
        end
    end

    assign DrawX        = h_count;
    assign DrawY        = v_count;
    assign blank        = blank_q;
    assign hs           = hs_q;
    assign vs           = vs_q;
    assign frame_start  = frame_start_q;
    assign vblank_start = vblank_start_q;
    assign frame_count  = frame_count_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - directed self-checking bench for vga_timing_gen
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #20 clk = ~clk;

    logic rst_a;
    logic rst_b;

    logic [9:0]  xa, ya, xb, yb;
    logic        bla, hsa, vsa, fsa, vba;
    logic        blb, hsb, vsb, fsb, vbb;
    logic [15:0] fca, fcb;

    int errors = 0;
    int checks = 0;

    localparam logic [40:0] RESET_VEC = {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0};

    // Full-size 640x480 timing
    vga_timing_gen dut_a (
        .vga_clk      (clk),
        .reset_n      (rst_a),
        .DrawX        (xa),
        .DrawY        (ya),
        .blank        (bla),
        .hs           (hsa),
        .vs           (vsa),
        .frame_start  (fsa),
        .vblank_start (vba),
        .frame_count  (fca)
    );

    // Shrunken raster (15 x 13, 195 clocks/frame) for frame-level behaviour
    vga_timing_gen #(
        .H_VISIBLE (8), .H_FRONT (2), .H_SYNC (3), .H_BACK (2),
        .V_VISIBLE (6), .V_FRONT (2), .V_SYNC (2), .V_BACK (3)
    ) dut_b (
        .vga_clk      (clk),
        .reset_n      (rst_b),
        .DrawX        (xb),
        .DrawY        (yb),
        .blank        (blb),
        .hs           (hsb),
        .vs           (vsb),
        .frame_start  (fsb),
        .vblank_start (vbb),
        .frame_count  (fcb)
    );

    function automatic logic [40:0] vec_a();
        return {xa, ya, bla, hsa, vsa, fsa, vba, fca};
    endfunction

    function automatic logic [40:0] vec_b();
        return {xb, yb, blb, hsb, vsb, fsb, vbb, fcb};
    endfunction

    task automatic test_reset();
        rst_a = 1'b0;
        rst_b = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (vec_a() !== RESET_VEC) begin
            errors++;
            $display("FAIL reset_a got=%h exp=%h", vec_a(), RESET_VEC);
        end
        checks++;
        if (vec_b() !== RESET_VEC) begin
            errors++;
            $display("FAIL reset_b got=%h exp=%h", vec_b(), RESET_VEC);
        end
    endtask

    task automatic test_first_line();
        logic [9:0] ex;
        logic [9:0] ey;
        logic       eb, ehs;
        logic       prev_bl;
        int         hs_low;
        int         fall_x;
        hs_low  = 0;
        fall_x  = -1;
        prev_bl = 1'b1;
        @(negedge clk);
        rst_a = 1'b1;
        for (int i = 1; i <= 801; i++) begin
            @(negedge clk);
            ex  = 10'(i % 800);
            ey  = (i >= 800) ? 10'd1 : 10'd0;
            eb  = (ex < 10'd640);
            ehs = !((ex >= 10'd656) && (ex < 10'd752));
            checks++;
            if (vec_a() !== {ex, ey, eb, ehs, 1'b1, 1'b0, 1'b0, 16'd0}) begin
                errors++;
                $display("FAIL line_a i=%0d got x=%0d y=%0d blank=%b hs=%b vs=%b fs=%b vb=%b fc=%0d exp x=%0d y=%0d blank=%b hs=%b",
                         i, xa, ya, bla, hsa, vsa, fsa, vba, fca, ex, ey, eb, ehs);
            end
            if (!hsa) hs_low++;
            if (prev_bl && !bla && fall_x < 0) fall_x = int'(xa);
            prev_bl = bla;
        end
        checks++;
        if (hs_low != 96) begin
            errors++;
            $display("FAIL hs_low_clocks got=%0d exp=96", hs_low);
        end
        checks++;
        if (fall_x != 640) begin
            errors++;
            $display("FAIL blank_fall_x got=%0d exp=640", fall_x);
        end
    endtask

    task automatic test_mid_line_reset_a();
        int n;
        n = 0;
        while (xa != 10'd400 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (xa != 10'd400) begin
            errors++;
            $display("FAIL reach_x400 got=%0d exp=400", xa);
        end
        @(posedge clk);
        #7 rst_a = 1'b0;
        #1;
        checks++;
        if (vec_a() !== RESET_VEC) begin
            errors++;
            $display("FAIL async_reset_a got=%h exp=%h", vec_a(), RESET_VEC);
        end
        @(negedge clk);
        rst_a = 1'b1;
        @(negedge clk);
        checks++;
        if (vec_a() !== {10'd1, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0}) begin
            errors++;
            $display("FAIL resume_a got x=%0d y=%0d vec=%h exp x=1 y=0", xa, ya, vec_a());
        end
    endtask

    task automatic test_frame_b();
        logic [9:0]  mx, my;
        logic        eb, ehs, evs, efs, evb;
        logic [15:0] efc;
        logic        prev_vs;
        int fs_count, vb_count, first_fs, second_fs, second_vb, vs_low_first;
        int fall_x, fall_y, rise_x, rise_y;
        fs_count = 0; vb_count = 0; first_fs = -1; second_fs = -1; second_vb = -1;
        vs_low_first = 0; fall_x = -1; fall_y = -1; rise_x = -1; rise_y = -1;
        prev_vs = 1'b1;
        @(negedge clk);
        rst_b = 1'b1;
        for (int c = 1; c <= 400; c++) begin
            @(negedge clk);
            mx  = 10'(c % 15);
            my  = 10'((c / 15) % 13);
            eb  = (mx < 10'd8) && (my < 10'd6);
            ehs = !((mx >= 10'd10) && (mx < 10'd13));
            evs = !((my >= 10'd8) && (my < 10'd10));
            efs = (mx == 10'd0) && (my == 10'd0);
            evb = (mx == 10'd0) && (my == 10'd6);
            efc = 16'(c / 195);
            checks++;
            if ($isunknown(vec_b()) || vec_b() !== {mx, my, eb, ehs, evs, efs, evb, efc}) begin
                errors++;
                $display("FAIL frame_b c=%0d got x=%0d y=%0d blank=%b hs=%b vs=%b fs=%b vb=%b fc=%0d exp x=%0d y=%0d blank=%b hs=%b vs=%b fs=%b vb=%b fc=%0d",
                         c, xb, yb, blb, hsb, vsb, fsb, vbb, fcb, mx, my, eb, ehs, evs, efs, evb, efc);
            end
            if (fsb === 1'b1) begin
                fs_count++;
                if (first_fs < 0) first_fs = c; else second_fs = c;
            end
            if (vbb === 1'b1) begin
                vb_count++;
                if (c > 195) second_vb = c;
            end
            if (c <= 195 && vsb === 1'b0) begin
                vs_low_first++;
                if (blb !== 1'b0) begin
                    checks++;
                    errors++;
                    $display("FAIL blank_in_vsync c=%0d got=%b exp=0", c, blb);
                end
            end
            if (prev_vs && !vsb && fall_x < 0) begin fall_x = int'(xb); fall_y = int'(yb); end
            if (!prev_vs && vsb && rise_x < 0) begin rise_x = int'(xb); rise_y = int'(yb); end
            prev_vs = vsb;
        end
        checks++;
        if (fs_count != 2 || first_fs != 195 || second_fs != 390) begin
            errors++;
            $display("FAIL frame_start_pulses got n=%0d at %0d,%0d exp n=2 at 195,390", fs_count, first_fs, second_fs);
        end
        checks++;
        if (vb_count != 2 || second_vb - second_fs != -105 || second_vb - first_fs != 90) begin
            errors++;
            $display("FAIL vblank_spacing got n=%0d second_vb=%0d exp n=2 second_vb=285", vb_count, second_vb);
        end
        checks++;
        if (vs_low_first != 30) begin
            errors++;
            $display("FAIL vs_low_clocks got=%0d exp=30", vs_low_first);
        end
        checks++;
        if (fall_x != 0 || fall_y != 8 || rise_x != 0 || rise_y != 10) begin
            errors++;
            $display("FAIL vs_edges got fall=(%0d,%0d) rise=(%0d,%0d) exp fall=(0,8) rise=(0,10)", fall_x, fall_y, rise_x, rise_y);
        end
    endtask

    task automatic test_async_reset_b();
        int n;
        n = 0;
        while (!(xb == 10'd4 && yb == 10'd3) && n < 400) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!(xb == 10'd4 && yb == 10'd3)) begin
            errors++;
            $display("FAIL reach_4_3 got=(%0d,%0d) exp=(4,3)", xb, yb);
        end
        @(posedge clk);
        #9 rst_b = 1'b0;
        #1;
        checks++;
        if (vec_b() !== RESET_VEC) begin
            errors++;
            $display("FAIL async_reset_b got=%h exp=%h", vec_b(), RESET_VEC);
        end
        @(negedge clk);
        rst_b = 1'b1;
        @(negedge clk);
        checks++;
        if (vec_b() !== {10'd1, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0}) begin
            errors++;
            $display("FAIL resume_b got x=%0d y=%0d vec=%h exp x=1 y=0", xb, yb, vec_b());
        end
    endtask

    task automatic test_frame_count_wrap_b();
        int n;
        repeat (20) @(negedge clk);
        force dut_b.frame_count_q = 16'hFFFF;
        #1;
        release dut_b.frame_count_q;
        @(negedge clk);
        checks++;
        if (fcb !== 16'hFFFF || fsb !== 1'b0) begin
            errors++;
            $display("FAIL preload_count got fc=%h fs=%b exp fc=ffff fs=0", fcb, fsb);
        end
        n = 0;
        while (fsb !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (fsb !== 1'b1 || fcb !== 16'h0000 || xb !== 10'd0 || yb !== 10'd0) begin
            errors++;
            $display("FAIL count_wrap got fs=%b fc=%h pos=(%0d,%0d) exp fs=1 fc=0000 pos=(0,0)", fsb, fcb, xb, yb);
        end
    endtask

    initial begin
        test_reset();
        test_first_line();
        test_mid_line_reset_a();
        test_frame_b();
        test_async_reset_b();
        test_frame_count_wrap_b();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
